// File: rtl/life_pkg.sv
// Shared types and width helpers for the life controller and its tick prescaler.
package life_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    NOTIFY = 2'd1,
    GUARD  = 2'd2,
    DEAD   = 2'd3
  } life_state_e;

  // Tick counter must reach the longer of the two windows.
  function automatic int tick_cnt_w(input int notify_ticks, input int guard_ticks);
    int longest;
    longest = (notify_ticks > guard_ticks) ? notify_ticks : guard_ticks;
    return $clog2(longest + 1);
  endfunction

  function automatic int presc_w(input int tick_div);
    return $clog2(tick_div);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler with synchronous clear; emits a one-cycle tick every TICK_DIV clocks.
module tick_gen
  import life_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W = presc_w(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/life_ctrl.sv
// Player life tracker: turns hit/bonus edges into a life count, an active-low
// life_change notify window, an invulnerability guard period and a game-over flag.
module life_ctrl
  import life_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int NOTIFY_TICKS = 200,
  parameter int GUARD_TICKS  = 500,
  parameter int MAX_LIVES    = 3,
  parameter int LIFE_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hit,
  input  logic              bonus,
  input  logic              restart,
  output logic [LIFE_W-1:0] lives,
  output logic              life_change,
  output logic              invuln,
  output logic              game_over
);

  localparam int               CNT_W       = tick_cnt_w(NOTIFY_TICKS, GUARD_TICKS);
  localparam logic [CNT_W-1:0] NOTIFY_LAST = CNT_W'(NOTIFY_TICKS - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_TICKS - 1);
  localparam logic [LIFE_W-1:0] LIVES_MAX  = LIFE_W'(MAX_LIVES);

  life_state_e       state, state_next;
  logic              hit_q, bonus_q;
  logic              hit_e, bonus_e;
  logic              tick, win_clr, window_done;
  logic [CNT_W-1:0]  tick_cnt;
  logic [LIFE_W-1:0] lives_next;
  logic              life_change_next, invuln_next, game_over_next;

  // Edge registers track the inputs even during rst/restart, so a level held
  // across a reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    hit_q   <= hit;
    bonus_q <= bonus;
  end

  assign hit_e   = hit & ~hit_q;
  assign bonus_e = bonus & ~bonus_q;

  // Timers restart on every state entry so each window is an exact multiple of TICK_DIV.
  assign win_clr = restart | (state_next != state);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (win_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst || win_clr) begin
      tick_cnt <= '0;
    end else if (tick && (state == NOTIFY || state == GUARD)) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_comb begin
    window_done = 1'b0;
    if (tick) begin
      if (state == NOTIFY) window_done = (tick_cnt == NOTIFY_LAST);
      if (state == GUARD)  window_done = (tick_cnt == GUARD_LAST);
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ALIVE:   if (hit_e) state_next = NOTIFY;
      NOTIFY:  if (window_done) state_next = (lives != '0) ? GUARD : DEAD;
      GUARD:   if (window_done) state_next = ALIVE;
      DEAD:    state_next = DEAD;
      default: state_next = ALIVE;
    endcase
  end

  always_comb begin
    lives_next = lives;
    unique case (state)
      ALIVE: begin
        if (hit_e) begin
          lives_next = lives - 1'b1;
        end else if (bonus_e && lives != LIVES_MAX) begin
          lives_next = lives + 1'b1;
        end
      end
      GUARD:   if (bonus_e && lives != LIVES_MAX) lives_next = lives + 1'b1;
      default: lives_next = lives;
    endcase
    life_change_next = (state_next != NOTIFY);
    invuln_next      = (state_next == NOTIFY) || (state_next == GUARD);
    game_over_next   = (state_next == DEAD);
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state       <= ALIVE;
      lives       <= LIVES_MAX;
      life_change <= 1'b1;
      invuln      <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_next;
      lives       <= lives_next;
      life_change <= life_change_next;
      invuln      <= invuln_next;
      game_over   <= game_over_next;
    end
  end

endmodule

// File: tb/tb_life_ctrl.sv
// Self-checking bench for life_ctrl: directed scenarios plus random traffic against a cycle-count model.
module tb_life_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int NOTIFY_TICKS = 3;
  localparam int GUARD_TICKS  = 5;
  localparam int MAX_LIVES    = 3;
  localparam int LIFE_W       = 3;
  localparam int NOTIFY_CYC   = NOTIFY_TICKS * TICK_DIV;
  localparam int GUARD_CYC    = GUARD_TICKS * TICK_DIV;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              hit = 1'b0;
  logic              bonus = 1'b0;
  logic              restart = 1'b0;
  logic [LIFE_W-1:0] lives;
  logic              life_change, invuln, game_over;

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0 alive, 1 notify, 2 guard, 3 dead; 'left' counts remaining cycles of a window.
  int m_lives = MAX_LIVES;
  int m_phase = 0;
  int m_left  = 0;
  bit m_ph    = 1'b0;
  bit m_pb    = 1'b0;

  int low_cnt   = 0;
  int guard_cnt = 0;

  life_ctrl #(
    .TICK_DIV(TICK_DIV), .NOTIFY_TICKS(NOTIFY_TICKS), .GUARD_TICKS(GUARD_TICKS),
    .MAX_LIVES(MAX_LIVES), .LIFE_W(LIFE_W)
  ) dut (
    .clk(clk), .rst(rst), .hit(hit), .bonus(bonus), .restart(restart),
    .lives(lives), .life_change(life_change), .invuln(invuln), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit h, input bit b, input bit r, input bit rs);
    bit he, be;
    he   = h && !m_ph;
    be   = b && !m_pb;
    m_ph = h;
    m_pb = b;
    if (rs || r) begin
      m_lives = MAX_LIVES;
      m_phase = 0;
      m_left  = 0;
    end else begin
      case (m_phase)
        0: begin
          if (he) begin
            m_lives--;
            m_phase = 1;
            m_left  = NOTIFY_CYC;
          end else if (be && m_lives < MAX_LIVES) begin
            m_lives++;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = (m_lives > 0) ? 2 : 3;
            m_left  = (m_lives > 0) ? GUARD_CYC : 0;
          end
        end
        2: begin
          if (be && m_lives < MAX_LIVES) m_lives++;
          m_left--;
          if (m_left == 0) m_phase = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input bit h, input bit b, input bit r, input bit rs);
    logic [5:0] exp, got;
    @(negedge clk);
    hit = h; bonus = b; restart = r; rst = rs;
    @(posedge clk);
    model_step(h, b, r, rs);
    #1;
    exp = {LIFE_W'(m_lives), m_phase != 1, m_phase == 1 || m_phase == 2, m_phase == 3};
    got = {lives, life_change, invuln, game_over};
    check("outputs", 32'(got), 32'(exp));
    if (life_change === 1'b0) low_cnt++;
    if (invuln === 1'b1 && life_change === 1'b1) guard_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic new_game();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
  endtask

  initial begin
    // Reset with hit held high across the release: no decrement.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("reset_lives", 32'(lives), 32'(MAX_LIVES));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("held_through_reset", 32'(lives), 32'(MAX_LIVES));
    idle(3);

    // Single hit: exact notify and guard window lengths.
    low_cnt = 0; guard_cnt = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("single_hit_lives", 32'(lives), 32'd2);
    idle(40);
    check("notify_len", 32'(low_cnt), 32'(NOTIFY_CYC));
    check("guard_len", 32'(guard_cnt), 32'(GUARD_CYC));
    check("back_alive_invuln", 32'(invuln), 32'd0);

    // Hits during NOTIFY, GUARD and a long held hit: one decrement only.
    new_game();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(12);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    check("ignored_hits", 32'(lives), 32'd2);

    // Bonus inside GUARD restores a life without a notify.
    new_game();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(15);
    low_cnt = 0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(25);
    check("guard_bonus_lives", 32'(lives), 32'd3);
    check("guard_bonus_no_low", 32'(low_cnt), 32'd0);

    // Game over after three separated hits; then everything ignored.
    new_game();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("go_lives", 32'(lives), 32'(2 - k));
      idle(40);
    end
    check("game_over", 32'({game_over, invuln, life_change}), 32'b101);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    check("dead_stays", 32'({lives, game_over}), 32'({3'd0, 1'b1}));

    // Saturation, then simultaneous hit and bonus.
    new_game();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("bonus_sat", 32'(lives), 32'd3);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("simul_hit_wins", 32'({lives, life_change}), 32'({3'd2, 1'b0}));
    idle(40);

    // Restart mid-NOTIFY, then a fresh full window.
    new_game();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_mid_notify", 32'({lives, life_change, invuln}), 32'({3'd3, 1'b1, 1'b0}));
    idle(2);
    low_cnt = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(40);
    check("post_restart_notify_len", 32'(low_cnt), 32'(NOTIFY_CYC));

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 199) == 0, $urandom_range(0, 499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
